dff_timing_driver: RTL and testbench
====================================

// Module: dff_timing_driver
// PURPOSE
// - Stimulus-side counterpart of the posedge DFF cell with preset/clear and its specify timing checks.
// - Takes a command stream and drives dff_clock/dff_data/dff_preset/dff_clear.
// - Outputs always honour setup, hold, period, pulse-width and recovery limits, counted in base-clock ticks.
// - Sits in front of the dff instance in gate-level benches and FPGA timing rigs, so the DUT notifier never toggles.
// - Also tracks the q the cell must present (expected_q) for comparison.
// PARAMETERS
// T_SU   10  setup: min ticks dff_data stable before dff_clock rise
// T_HD    1  hold: min ticks dff_data stable after rise; elaboration check T_PW/2 > T_HD
// T_PW   25  period: min ticks between consecutive dff_clock rises; >= 4
// T_WPC  10  width: ticks dff_preset/dff_clear held low per pulse; >= 1
// T_REC   5  recovery: min ticks from preset/clear deassert to next dff_clock rise
// PORTS
// clock        in   1  base tick clock
// rst_n        in   1  asynchronous, active-low reset
// cmd_valid    in   1  command offered
// cmd_ready    out  1  command accepted when cmd_valid && cmd_ready
// cmd_op       in   2  0 CAPTURE, 1 PRESET, 2 CLEAR, 3 NOP
// cmd_data     in   1  data bit for CAPTURE; ignored otherwise
// dff_clock    out  1  clock to DFF
// dff_data     out  1  data to DFF
// dff_preset   out  1  preset to DFF, active-low
// dff_clear    out  1  clear to DFF, active-low
// expected_q   out  1  q the DFF must hold after the last completed command
// expected_vld out  1  expected_q meaningful
// done         out  1  one-tick pulse when a command completes
// BEHAVIOUR
// Reset (async, immediate):
// - state IDLE; dff_clock=0, dff_data=0, dff_preset=1, dff_clear=1, expected_q=0, expected_vld=0, done=0.
// - since_rise and since_rel counters saturated, so no wait is owed.
// - Reset mid-operation aborts the command; a preset/clear pulse ends immediately and no width check is honoured.
// cmd_ready:
// - cmd_ready=1 only in IDLE; all outputs are registered.
// - The command is accepted at edge A; its first effect is visible in cycle A+1.
// FSM states (IDLE, SETUP, HIGH, PULSE, NOP):
// - IDLE -> SETUP on CAPTURE: dff_data<=cmd_data, dff_clock stays 0.
// - SETUP lasts until all three hold:
//   - ticks in SETUP >= T_SU;
//   - since_rise >= T_PW - 1;
//   - since_rel >= T_REC - 1.
//   Then go to HIGH (rise edge at end of SETUP).
// - HIGH: dff_clock=1 for T_PW/2 ticks, dff_data frozen.
//   Then dff_clock<=0, expected_q<=dff_data, expected_vld<=1, done pulse, go to IDLE.
// - IDLE -> PULSE on PRESET/CLEAR: selected line low for exactly T_WPC ticks.
//   Then deassert, since_rel<=0; PRESET sets expected_q=1, CLEAR sets expected_q=0; expected_vld=1; done; IDLE.
// - IDLE -> NOP on NOP: one tick, done, IDLE; outputs unchanged.
// Counters:
// - since_rise resets at each rise edge; since_rel resets at each deassert.
// - Both saturate at their max and never wrap.
// - Width is clog2(max(T_PW,T_REC,T_SU,T_WPC)+1).
// Invariants:
// - dff_preset and dff_clear are never low together.
// - dff_data changes only in the cycle after a CAPTURE acceptance.
// - cmd_valid is ignored outside IDLE; the command is held upstream.
// STRUCTURE
// - Package dff_timing_pkg: op_e (CAPTURE/PRESET/CLEAR/NOP), state_e, default T_* localparams.
// - One sub-module dff_tick_timer: loadable down-counter with load/value/zero, reused for the SETUP, HIGH and PULSE phases.
// - The saturating since_* counters stay inline.
// TESTING (defaults unless noted; A = acceptance edge)
// 1 Single CAPTURE d=1 at A:
//   - dff_data=1 at A+1, dff_clock rise at A+11, high 12 ticks, falls at A+23;
//   - expected_q=1 and done at A+23.
// 2 Back-to-back CAPTURE 1,0:
//   - second rise exactly 25 ticks after the first (period-bound, not setup-bound);
//   - dff_data constant for 1+ tick after each rise.
// 3 PRESET at A:
//   - dff_preset low A+1..A+10, high at A+11, expected_q=1;
//   - then CAPTURE 0 with T_SU=2, T_REC=8: rise at A+19, not A+14.
// 4 CLEAR then PRESET:
//   - never both low; each pulse exactly 10 ticks; expected_q 0 then 1.
// 5 Async reset asserted mid-HIGH and mid-PULSE:
//   - dff_clock=0, dff_preset=dff_clear=1 same tick;
//   - after release, CAPTURE rises 10 ticks after data with no period wait.
// 6 cmd_valid held with cmd_op=NOP x3 then CAPTURE:
//   - three done pulses, cmd_ready drops 1 tick each;
//   - pins quiet until CAPTURE.

Source files
------------

// File: rtl/dff_timing_pkg.sv
// rtl/dff_timing_pkg.sv - shared types and defaults for the DFF timing driver
// Purpose: command opcodes, FSM state encodings, default timing limits and
//          the width helper used to size the tick counters.
package dff_timing_pkg;

  typedef enum logic [1:0] {
    OP_CAPTURE = 2'd0,
    OP_PRESET  = 2'd1,
    OP_CLEAR   = 2'd2,
    OP_NOP     = 2'd3
  } op_e;

  typedef logic [2:0] state_e;

  localparam state_e ST_IDLE  = 3'd0;
  localparam state_e ST_SETUP = 3'd1;
  localparam state_e ST_HIGH  = 3'd2;
  localparam state_e ST_PULSE = 3'd3;
  localparam state_e ST_NOP   = 3'd4;

  localparam int DEF_T_SU  = 10;
  localparam int DEF_T_HD  = 1;
  localparam int DEF_T_PW  = 25;
  localparam int DEF_T_WPC = 10;
  localparam int DEF_T_REC = 5;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/dff_tick_timer.sv
// rtl/dff_tick_timer.sv - loadable down-counter timing one FSM phase
// Purpose: holds the remaining ticks of the current phase; zero means the
//          current tick is the last one of the phase.
// Ports:
//   clock      in  base tick clock
//   rst_n      in  asynchronous active-low reset
//   load       in  load load_value this edge (wins over counting)
//   load_value in  W  value to load
//   value      out W  remaining count
//   zero       out    value == 0
module dff_tick_timer #(
  parameter int W = 5
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_value;
    end else if (value_q != '0) begin
      value_d = value_q - W'(1);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

  assign value = value_q;
  assign zero  = (value_q == '0);

endmodule

// File: rtl/dff_timing_driver.sv
// rtl/dff_timing_driver.sv - command-driven stimulus for a preset/clear DFF
// Purpose: turns CAPTURE/PRESET/CLEAR/NOP commands into dff_clock/dff_data/
//          dff_preset/dff_clear waveforms that always meet setup, hold,
//          period, pulse-width and recovery limits, and tracks the q the
//          cell must show afterwards.
// Ports:
//   clock, rst_n            base tick clock, async active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only in IDLE)
//   cmd_op[1:0], cmd_data   opcode and CAPTURE data bit
//   dff_clock, dff_data     clock and data to the DFF
//   dff_preset, dff_clear   active-low preset/clear to the DFF
//   expected_q/expected_vld q the DFF must hold, and whether it is known
//   done                    one-tick pulse on command completion
module dff_timing_driver
  import dff_timing_pkg::*;
#(
  parameter int T_SU  = DEF_T_SU,
  parameter int T_HD  = DEF_T_HD,
  parameter int T_PW  = DEF_T_PW,
  parameter int T_WPC = DEF_T_WPC,
  parameter int T_REC = DEF_T_REC
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_data,
  output logic       dff_clock,
  output logic       dff_data,
  output logic       dff_preset,
  output logic       dff_clear,
  output logic       expected_q,
  output logic       expected_vld,
  output logic       done
);

  localparam int CW = $clog2(max4(T_PW, T_REC, T_SU, T_WPC) + 1);

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] ONE      = CW'(1);
  // Timer loads are "ticks - 1": the phase ends on the tick where the timer reads zero.
  localparam logic [CW-1:0] SU_LOAD  = CW'((T_SU > 0) ? T_SU - 1 : 0);
  localparam logic [CW-1:0] HI_LOAD  = CW'(T_PW / 2 - 1);
  localparam logic [CW-1:0] WPC_LOAD = CW'(T_WPC - 1);
  // The rise is registered at the end of the checking tick, so one tick less is owed.
  localparam logic [CW-1:0] PW_MIN   = CW'(T_PW - 1);
  localparam logic [CW-1:0] REC_MIN  = CW'((T_REC > 0) ? T_REC - 1 : 0);

  if (T_PW < 4) begin : g_bad_pw
    $error("dff_timing_driver: T_PW must be >= 4");
  end
  if (T_WPC < 1) begin : g_bad_wpc
    $error("dff_timing_driver: T_WPC must be >= 1");
  end
  if (T_PW / 2 <= T_HD) begin : g_bad_hd
    $error("dff_timing_driver: T_PW/2 must exceed T_HD");
  end

  state_e        state_q, state_d;
  logic          ready_q, ready_d;
  logic          clk_q, clk_d;
  logic          data_q, data_d;
  logic          preset_q, preset_d;
  logic          clear_q, clear_d;
  logic          eq_q, eq_d;
  logic          evld_q, evld_d;
  logic          done_q, done_d;
  logic [CW-1:0] since_rise_q, since_rise_d;
  logic [CW-1:0] since_rel_q, since_rel_d;

  logic          tmr_load;
  logic [CW-1:0] tmr_load_value;
  logic [CW-1:0] tmr_value;
  logic          tmr_zero;
  logic          rise;
  logic          release_pulse;

  dff_tick_timer #(.W(CW)) u_timer (
    .clock      (clock),
    .rst_n      (rst_n),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .value      (tmr_value),
    .zero       (tmr_zero)
  );

  always_comb begin
    state_d        = state_q;
    clk_d          = clk_q;
    data_d         = data_q;
    preset_d       = preset_q;
    clear_d        = clear_q;
    eq_d           = eq_q;
    evld_d         = evld_q;
    done_d         = 1'b0;
    tmr_load       = 1'b0;
    tmr_load_value = '0;
    rise           = 1'b0;
    release_pulse  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (op_e'(cmd_op))
            OP_CAPTURE: begin
              data_d         = cmd_data;
              tmr_load       = 1'b1;
              tmr_load_value = SU_LOAD;
              state_d        = ST_SETUP;
            end
            OP_PRESET: begin
              preset_d       = 1'b0;
              tmr_load       = 1'b1;
              tmr_load_value = WPC_LOAD;
              state_d        = ST_PULSE;
            end
            OP_CLEAR: begin
              clear_d        = 1'b0;
              tmr_load       = 1'b1;
              tmr_load_value = WPC_LOAD;
              state_d        = ST_PULSE;
            end
            default: state_d = ST_NOP;
          endcase
        end
      end
      ST_SETUP: begin
        if (tmr_zero && (since_rise_q >= PW_MIN) && (since_rel_q >= REC_MIN)) begin
          clk_d          = 1'b1;
          rise           = 1'b1;
          tmr_load       = 1'b1;
          tmr_load_value = HI_LOAD;
          state_d        = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (tmr_zero) begin
          clk_d   = 1'b0;
          eq_d    = data_q;
          evld_d  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_PULSE: begin
        if (tmr_zero) begin
          // Whichever line is low identifies the pulse: preset low -> q=1.
          eq_d          = ~preset_q;
          preset_d      = 1'b1;
          clear_d       = 1'b1;
          release_pulse = 1'b1;
          evld_d        = 1'b1;
          done_d        = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_NOP: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);

    if (rise)                        since_rise_d = '0;
    else if (since_rise_q == CNT_MAX) since_rise_d = since_rise_q;
    else                             since_rise_d = since_rise_q + ONE;

    if (release_pulse)               since_rel_d = '0;
    else if (since_rel_q == CNT_MAX)  since_rel_d = since_rel_q;
    else                             since_rel_d = since_rel_q + ONE;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b1;
      clk_q        <= 1'b0;
      data_q       <= 1'b0;
      preset_q     <= 1'b1;
      clear_q      <= 1'b1;
      eq_q         <= 1'b0;
      evld_q       <= 1'b0;
      done_q       <= 1'b0;
      since_rise_q <= CNT_MAX;
      since_rel_q  <= CNT_MAX;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      clk_q        <= clk_d;
      data_q       <= data_d;
      preset_q     <= preset_d;
      clear_q      <= clear_d;
      eq_q         <= eq_d;
      evld_q       <= evld_d;
      done_q       <= done_d;
      since_rise_q <= since_rise_d;
      since_rel_q  <= since_rel_d;
    end
  end

  assign cmd_ready    = ready_q;
  assign dff_clock    = clk_q;
  assign dff_data     = data_q;
  assign dff_preset   = preset_q;
  assign dff_clear    = clear_q;
  assign expected_q   = eq_q;
  assign expected_vld = evld_q;
  assign done         = done_q;

endmodule

// File: tb/tb_dff_timing_driver.sv
// tb/tb_dff_timing_driver.sv - directed self-checking bench for dff_timing_driver
module tb_dff_timing_driver;
  import dff_timing_pkg::*;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;

  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd3;
  logic       cmd_data = 1'b0;
  logic       cmd_ready, dff_clock, dff_data, dff_preset, dff_clear;
  logic       expected_q, expected_vld, done;

  logic       cmd_valid_2 = 1'b0;
  logic [1:0] cmd_op_2 = 2'd3;
  logic       cmd_data_2 = 1'b0;
  logic       cmd_ready_2, dff_clock_2, dff_data_2, dff_preset_2, dff_clear_2;
  logic       expected_q_2, expected_vld_2, done_2;

  int checks = 0;
  int errors = 0;
  int k = 0;

  always #5 clock = ~clock;

  dff_timing_driver u_dut (
    .clock(clock), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .dff_clock(dff_clock), .dff_data(dff_data), .dff_preset(dff_preset), .dff_clear(dff_clear),
    .expected_q(expected_q), .expected_vld(expected_vld), .done(done)
  );

  dff_timing_driver #(.T_SU(2), .T_REC(8)) u_dut2 (
    .clock(clock), .rst_n(rst_n),
    .cmd_valid(cmd_valid_2), .cmd_ready(cmd_ready_2), .cmd_op(cmd_op_2), .cmd_data(cmd_data_2),
    .dff_clock(dff_clock_2), .dff_data(dff_data_2), .dff_preset(dff_preset_2), .dff_clear(dff_clear_2),
    .expected_q(expected_q_2), .expected_vld(expected_vld_2), .done(done_2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (k=%0d): observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      k++;
    end
  endtask

  task automatic goto(input int t);
    step(t - k);
  endtask

  // Offers one command at a negedge where the DUT is idle; returns in cycle A+1 (k=1 on a fresh k).
  task automatic issue(input logic [1:0] op, input logic d);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    step(1);
    cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = 1'b0;
  endtask

  task automatic issue2(input logic [1:0] op, input logic d);
    cmd_valid_2 = 1'b1; cmd_op_2 = op; cmd_data_2 = d;
    step(1);
    cmd_valid_2 = 1'b0; cmd_op_2 = OP_NOP; cmd_data_2 = 1'b0;
  endtask

  initial begin
    step(2);
    rst_n = 1'b1;
    step(2);

    // Reset state
    chk("rst_clock", dff_clock, 0);
    chk("rst_data", dff_data, 0);
    chk("rst_preset", dff_preset, 1);
    chk("rst_clear", dff_clear, 1);
    chk("rst_eq", expected_q, 0);
    chk("rst_evld", expected_vld, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);

    // 1: single CAPTURE d=1
    k = 0;
    issue(OP_CAPTURE, 1'b1);
    chk("t1_data", dff_data, 1);
    chk("t1_ready_low", cmd_ready, 0);
    goto(10); chk("t1_clk_before_rise", dff_clock, 0);
    goto(11); chk("t1_rise", dff_clock, 1);
    goto(22); chk("t1_still_high", dff_clock, 1);
    chk("t1_no_done_yet", done, 0);
    goto(23); chk("t1_fall", dff_clock, 0);
    chk("t1_eq", expected_q, 1);
    chk("t1_evld", expected_vld, 1);
    chk("t1_done", done, 1);
    goto(24); chk("t1_done_pulse", done, 0);

    // 3: PRESET then period-independent recovery wait on the T_SU=2/T_REC=8 instance
    k = 0;
    issue2(OP_PRESET, 1'b0);
    chk("t3_preset_low_first", dff_preset_2, 0);
    goto(10); chk("t3_preset_low_last", dff_preset_2, 0);
    goto(11); chk("t3_preset_release", dff_preset_2, 1);
    chk("t3_eq", expected_q_2, 1);
    chk("t3_done", done_2, 1);
    issue2(OP_CAPTURE, 1'b0);
    chk("t3_data", dff_data_2, 0);
    goto(14); chk("t3_no_rise_setup_only", dff_clock_2, 0);
    goto(18); chk("t3_no_rise_recovery", dff_clock_2, 0);
    goto(19); chk("t3_rise", dff_clock_2, 1);
    goto(31); chk("t3_fall", dff_clock_2, 0);
    chk("t3_eq_after", expected_q_2, 0);

    // 2: back-to-back CAPTURE 1,0 (second rise period-bound)
    step(30);
    k = 0;
    issue(OP_CAPTURE, 1'b1);
    goto(11); chk("t2_rise1", dff_clock, 1);
    goto(12); chk("t2_hold1", dff_data, 1);
    goto(23); chk("t2_done1", done, 1);
    issue(OP_CAPTURE, 1'b0);
    chk("t2_data2", dff_data, 0);
    goto(34); chk("t2_wait_period_a", dff_clock, 0);
    goto(35); chk("t2_wait_period_b", dff_clock, 0);
    goto(36); chk("t2_rise2", dff_clock, 1);
    goto(37); chk("t2_hold2", dff_data, 0);
    goto(48); chk("t2_fall2", dff_clock, 0);
    chk("t2_eq2", expected_q, 0);

    // 4: CLEAR then PRESET
    step(2);
    k = 0;
    issue(OP_CLEAR, 1'b0);
    chk("t4_clear_low", dff_clear, 0);
    chk("t4_preset_high_a", dff_preset, 1);
    goto(10); chk("t4_clear_low_last", dff_clear, 0);
    goto(11); chk("t4_clear_release", dff_clear, 1);
    chk("t4_eq_clear", expected_q, 0);
    chk("t4_done_clear", done, 1);
    issue(OP_PRESET, 1'b0);
    chk("t4_preset_low", dff_preset, 0);
    chk("t4_clear_high", dff_clear, 1);
    goto(21); chk("t4_preset_low_last", dff_preset, 0);
    goto(22); chk("t4_preset_release", dff_preset, 1);
    chk("t4_eq_preset", expected_q, 1);

    // 5: async reset mid-HIGH and mid-PULSE
    step(30);
    k = 0;
    issue(OP_CAPTURE, 1'b1);
    goto(15); chk("t5_in_high", dff_clock, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_clock", dff_clock, 0);
    chk("t5_rst_evld", expected_vld, 0);
    chk("t5_rst_ready", cmd_ready, 1);
    step(1);
    rst_n = 1'b1;
    step(1);
    k = 0;
    issue(OP_PRESET, 1'b0);
    goto(5); chk("t5_in_pulse", dff_preset, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_preset", dff_preset, 1);
    chk("t5_rst_clear", dff_clear, 1);
    step(1);
    rst_n = 1'b1;
    step(1);
    k = 0;
    issue(OP_CAPTURE, 1'b1);
    chk("t5_data", dff_data, 1);
    goto(10); chk("t5_before_rise", dff_clock, 0);
    goto(11); chk("t5_rise_no_period_wait", dff_clock, 1);
    goto(23); chk("t5_eq", expected_q, 1);

    // 6: cmd_valid held, NOP x3 then CAPTURE 0
    step(1);
    k = 0;
    cmd_valid = 1'b1; cmd_op = OP_NOP; cmd_data = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      chk("t6_ready", cmd_ready, (i % 2 == 0) ? 1 : 0);
      chk("t6_done", done, (i % 2 == 0) ? 1 : 0);
      chk("t6_quiet_clock", dff_clock, 0);
      chk("t6_quiet_data", dff_data, 1);
    end
    cmd_op = OP_CAPTURE;
    step(1);
    cmd_valid = 1'b0; cmd_op = OP_NOP;
    chk("t6_capture_data", dff_data, 0);
    goto(16); chk("t6_before_rise", dff_clock, 0);
    goto(17); chk("t6_rise", dff_clock, 1);
    goto(29); chk("t6_fall", dff_clock, 0);
    chk("t6_eq", expected_q, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
